// File: rtl/product_bcd_converter_if.sv
// Handshake/data bundle between the multiplier result path and the BCD converter.
// The master side issues start/p; the slave side returns busy/done/bcd.
interface product_bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      p;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output p,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  start,
    input  p,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock,
// result published with a one-cycle done pulse and held until the next result.
module product_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  product_bcd_converter_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  bin_sr;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  scratch_adj;
  logic [BCD_W-1:0]  scratch_shf;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt;
  logic              last_iter;

  // Every digit >= 5 is pre-corrected by +3 so the following doubling carries
  // into the next decade exactly when the digit would exceed 9.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign scratch_adj = dabble_adjust(scratch);
  assign scratch_shf = {scratch_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CONVERT;
      CONVERT: if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr  <= bus.p;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        CONVERT: begin
          bin_sr  <= bin_sr << 1;
          scratch <= scratch_shf;
          cnt     <= cnt + 1'b1;
          // Only the completed value is published; partial sums stay internal.
          if (last_iter) begin
            bcd_q <= scratch_shf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: vector table, corner-case
// sequences and a full 0..255 sweep, all checked through an expected-result queue.
module tb_product_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic clk;
  logic rst_n;

  product_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) ifc ();

  product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  p;
    logic [11:0] bcd;
  } vec_t;

  vec_t        vecs[12];
  logic [11:0] sb[$];
  int          n_cmp;
  int          n_err;
  logic        prev_done;
  logic [11:0] last_bcd;

  function automatic logic [11:0] dec_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Advance one edge and check what the DUT shows just after it.
  task automatic tick();
    logic r;
    r = rst_n;
    @(posedge clk);
    #1;
    if (!r) begin
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_done", 32'(ifc.done), 32'd0);
      chk("rst_bcd", 32'(ifc.bcd), 32'd0);
      sb.delete();
      prev_done = 1'b0;
      last_bcd  = '0;
    end else begin
      if (ifc.done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 bcd=%0h required no pending conversion", ifc.bcd);
        end else begin
          chk("bcd", 32'(ifc.bcd), 32'(sb.pop_front()));
        end
        chk("done_pulse_width", 32'(prev_done), 32'd0);
      end else begin
        chk("bcd_hold", 32'(ifc.bcd), 32'(last_bcd));
      end
      prev_done = ifc.done;
      last_bcd  = ifc.bcd;
    end
  endtask

  // mode 0: plain; 1: re-pulse start (p=7) during CONVERT and DONE; 2: change p after acceptance
  task automatic run_conv(input logic [7:0] v, input logic [11:0] e, input int mode);
    int lat;
    int busycnt;
    ifc.start = 1'b1;
    ifc.p     = v;
    sb.push_back(e);
    tick();
    ifc.start = 1'b0;
    chk("busy_at_accept", 32'(ifc.busy), 32'd1);
    if (mode == 2) ifc.p = 8'd200;
    lat     = 0;
    busycnt = 1;
    while (!ifc.done && lat < WIDTH + 4) begin
      ifc.start = (mode == 1 && lat == 3);
      if (ifc.start) ifc.p = 8'd7;
      tick();
      lat++;
      if (ifc.busy) busycnt++;
    end
    chk("latency", 32'(lat), 32'(WIDTH));
    ifc.start = (mode == 1);
    if (mode == 1) ifc.p = 8'd7;
    tick();
    ifc.start = 1'b0;
    chk("busy_fall", 32'(ifc.busy), 32'd0);
    chk("busy_cycles", 32'(busycnt), 32'(WIDTH + 1));
    if (mode == 1) begin
      repeat (WIDTH + 3) tick();
      chk("no_second_conv", 32'(ifc.busy), 32'd0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    prev_done = 1'b0;
    last_bcd  = '0;
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.p     = '0;

    vecs[0]  = '{8'd0,   12'h000};
    vecs[1]  = '{8'd225, 12'h225};
    vecs[2]  = '{8'd99,  12'h099};
    vecs[3]  = '{8'd100, 12'h100};
    vecs[4]  = '{8'd255, 12'h255};
    vecs[5]  = '{8'd1,   12'h001};
    vecs[6]  = '{8'd9,   12'h009};
    vecs[7]  = '{8'd10,  12'h010};
    vecs[8]  = '{8'd128, 12'h128};
    vecs[9]  = '{8'd199, 12'h199};
    vecs[10] = '{8'd50,  12'h050};
    vecs[11] = '{8'd169, 12'h169};

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(ifc.busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].p, vecs[i].bcd, 0);
    end

    run_conv(8'd42, 12'h042, 1);
    run_conv(8'd13, 12'h013, 2);

    // Abort a conversion of 180 with reset at iteration 4.
    ifc.start = 1'b1;
    ifc.p     = 8'd180;
    sb.push_back(12'h180);
    tick();
    ifc.start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (WIDTH + 4) tick();
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_bcd", 32'(ifc.bcd), 32'd0);
    run_conv(8'd180, 12'h180, 0);

    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), dec_bcd(v), 0);
    end

    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential binary-to-BCD converter (iterative double-dabble) that consumes the 8-bit unsigned product from the 4x4 carry-save array multiplier and produces three packed BCD digits for the calculator's seven-segment display path. It samples the product on a `start` pulse and converts one bit per clock. It presents the result with a one-cycle `done` pulse and holds it until the next conversion completes.

## Interface
- `WIDTH`, default 8: width of the binary input. Sets the number of conversion iterations.
- `DIGITS`, default 3: number of BCD output digits. The integrator must guarantee 10^DIGITS > 2^WIDTH - 1; the block does not check this.

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: conversion request. Sampled only in IDLE.
- `p` input WIDTH: unsigned binary operand (multiplier product). Sampled only on the accepted `start` edge.
- `busy` output 1: high while a conversion is in progress (states CONVERT and DONE).
- `done` output 1: one-cycle pulse, registered. `bcd` is valid while it is high.
- `bcd` output 4*DIGITS: packed BCD. `[3:0]` is ones, `[7:4]` is tens, `[11:8]` is hundreds. Held between conversions.

## Operation
- Internal registers:
  - `bin_sr` (WIDTH): binary shift register.
  - `scratch` (4*DIGITS): BCD accumulator.
  - `cnt`: iteration counter, ceil(log2(WIDTH)) bits.
  - `state`.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - If `start`=1: `bin_sr` <= `p`, `scratch` <= 0, `cnt` <= 0, go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT, one iteration per cycle:
  - Adjust: every 4-bit digit of `scratch` that is >= 5 gets +3 (computed combinationally on all digits in parallel).
  - Shift: `{scratch, bin_sr}` is shifted left by 1, with the MSB of `bin_sr` entering the LSB of `scratch`.
  - `cnt` increments.
  - On the iteration where `cnt` = WIDTH-1: `bcd` <= the adjusted and shifted value, go to DONE.
- DONE:
  - `done`=1 for exactly this one cycle, then return unconditionally to IDLE.
- `start` is ignored in CONVERT and DONE. It is neither queued nor counted.
- A change in `p` after the accepted `start` edge has no effect on the conversion in flight.
- `bcd` changes only on the CONVERT->DONE edge, or on reset. It never shows partial results.
- Overflow is not possible for legal parameters. The maximum multiplier product, 225 (15x15), must yield 0x225.

## Timing
- Reset, with `rst_n`=0 at a rising edge:
  - `state`=IDLE.
  - `busy`=0, `done`=0, `bcd`=0.
  - Internal registers cleared.
- Reset during CONVERT or DONE aborts the conversion. `bcd` reads 0, not the previous result. `done` is not asserted.
- Reset has priority over `start` on the same edge.
- Latency, with `start` accepted at edge k:
  - `busy`=1 from edge k.
  - WIDTH iterations on edges k+1 .. k+WIDTH.
  - `done`=1 and new `bcd` from edge k+WIDTH to edge k+WIDTH+1.
  - `busy`=0 from edge k+WIDTH+1.
  - For WIDTH=8: the result appears 8 edges after acceptance.
- Throughput: the earliest next acceptance is edge k+WIDTH+2, giving one conversion per WIDTH+2 cycles.
- A `start` held high continuously restarts a conversion at each IDLE cycle. The result is `p` as sampled at each acceptance.
- `busy` and `done` are registered (decoded from `state` flops). There are no combinational paths from inputs to outputs.

## Test plan
- Reset release, then `p`=0 and one-cycle `start` -> `busy` high for 9 cycles, `done` pulses once 8 edges after acceptance, `bcd`=0x000.
- `p`=225 (15x15 from the multiplier), then `p`=99, then `p`=100, then `p`=255, back-to-back with `start` asserted as soon as `busy` falls -> `bcd`=0x225, 0x099, 0x100, 0x255 respectively; each `done` is a single cycle; `bcd` is stable between pulses.
- `p`=42 with `start`, then `start` re-pulsed during CONVERT and during DONE while `p`=7 -> a single `done`, `bcd`=0x042, no second conversion.
- `p`=13 with `start`, then `p` changed to 200 on the following cycle -> `bcd`=0x013.
- `rst_n`=0 for one edge at iteration 4 of a conversion of `p`=180 -> `busy`=0, `done` never asserts, `bcd`=0x000. A subsequent `start` with `p`=180 -> `bcd`=0x180.
- Exhaustive sweep: all `p` in 0..255 -> `bcd` equals the decimal digits of `p`, latency exactly 8 edges each time.
